// File: rtl/sdram_fifo_sched.sv
// Write/read burst scheduler between camera/display FIFOs and an SDRAM arbiter.
// Optional macro PINGPONG_EN enables double-buffered frame banks.
module sdram_fifo_sched #(
    parameter int          BURST_LEN  = 256,
    parameter logic [12:0] FRAME_ROWS = 13'd1200,
    parameter logic [9:0]  RD_LOW     = 10'd256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_init_end,
    input  logic [9:0]  wfifo_usedw,
    input  logic [9:0]  rfifo_usedw,
    input  logic        flag_wr_end,
    input  logic        flag_rd_end,
    output logic        wr_req,
    output logic        rd_req,
    output logic [12:0] wr_row,
    output logic [8:0]  wr_col,
    output logic [12:0] rd_row,
    output logic [8:0]  rd_col,
    output logic [1:0]  sdram_bank_addr,
    output logic [1:0]  rd_bank,
    output logic        wr_frame_done
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WR, S_RD} state_t;

    localparam logic [9:0]  BURST_STEP = 10'(BURST_LEN);
    localparam logic [12:0] LAST_ROW   = FRAME_ROWS - 13'd1;

    state_t      state;
    logic [9:0]  wr_col_sum;
    logic [9:0]  rd_col_sum;
    logic        wr_wrap;
    logic        rd_wrap;
    logic        wr_frame_evt;
    logic        rd_frame_evt;

    // Bit 9 of the sum marks the column wrapping past 512 into the next row.
    assign wr_col_sum   = {1'b0, wr_col} + BURST_STEP;
    assign rd_col_sum   = {1'b0, rd_col} + BURST_STEP;
    assign wr_wrap      = wr_col_sum[9];
    assign rd_wrap      = rd_col_sum[9];
    assign wr_frame_evt = (state == S_WR) && flag_wr_end && wr_wrap && (wr_row == LAST_ROW);
    assign rd_frame_evt = (state == S_RD) && flag_rd_end && rd_wrap && (rd_row == LAST_ROW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_INIT;
            wr_req        <= 1'b0;
            rd_req        <= 1'b0;
            wr_row        <= 13'd0;
            wr_col        <= 9'd0;
            rd_row        <= 13'd0;
            rd_col        <= 9'd0;
            wr_frame_done <= 1'b0;
        end else begin
            wr_frame_done <= 1'b0;
            case (state)
                S_INIT: begin
                    if (flag_init_end) state <= S_IDLE;
                end
                S_IDLE: begin
                    // Write wins over read so camera data never overflows.
                    if (wfifo_usedw >= BURST_STEP) begin
                        wr_req <= 1'b1;
                        state  <= S_WR;
                    end else if (rfifo_usedw < RD_LOW) begin
                        rd_req <= 1'b1;
                        state  <= S_RD;
                    end
                end
                S_WR: begin
                    if (flag_wr_end) begin
                        wr_req <= 1'b0;
                        state  <= S_IDLE;
                        wr_col <= wr_col_sum[8:0];
                        if (wr_wrap) begin
                            if (wr_row == LAST_ROW) begin
                                wr_row        <= 13'd0;
                                wr_frame_done <= 1'b1;
                            end else begin
                                wr_row <= wr_row + 13'd1;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (flag_rd_end) begin
                        rd_req <= 1'b0;
                        state  <= S_IDLE;
                        rd_col <= rd_col_sum[8:0];
                        if (rd_wrap) begin
                            if (rd_row == LAST_ROW) rd_row <= 13'd0;
                            else                    rd_row <= rd_row + 13'd1;
                        end
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef PINGPONG_EN
    logic [1:0] last_wr_bank;
    logic       frame_seen;

    // Reader switches to the most recently completed frame only at its own
    // frame boundary, so it never lands on the bank being filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_bank_addr <= 2'd0;
            rd_bank         <= 2'd0;
            last_wr_bank    <= 2'd0;
            frame_seen      <= 1'b0;
        end else begin
            if (wr_frame_evt) begin
                last_wr_bank    <= sdram_bank_addr;
                frame_seen      <= 1'b1;
                sdram_bank_addr <= {1'b0, ~sdram_bank_addr[0]};
            end
            if (rd_frame_evt && frame_seen) rd_bank <= last_wr_bank;
        end
    end
`else
    logic unused_evt;
    assign unused_evt      = wr_frame_evt ^ rd_frame_evt;
    assign sdram_bank_addr = 2'd0;
    assign rd_bank         = 2'd0;
`endif

endmodule

// File: tb/tb_sdram_fifo_sched.sv
// Directed self-checking bench for sdram_fifo_sched.
module tb_sdram_fifo_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_init_end;
    logic [9:0]  wfifo_usedw;
    logic [9:0]  rfifo_usedw;
    logic        flag_wr_end;
    logic        flag_rd_end;
    logic        wr_req;
    logic        rd_req;
    logic [12:0] wr_row;
    logic [8:0]  wr_col;
    logic [12:0] rd_row;
    logic [8:0]  rd_col;
    logic [1:0]  sdram_bank_addr;
    logic [1:0]  rd_bank;
    logic        wr_frame_done;

    int checks = 0;
    int errors = 0;

`ifdef PINGPONG_EN
    localparam logic [1:0] EXP_WBANK_AFTER_FRAME = 2'd1;
`else
    localparam logic [1:0] EXP_WBANK_AFTER_FRAME = 2'd0;
`endif

    sdram_fifo_sched dut (
        .clk(clk), .rst_n(rst_n), .flag_init_end(flag_init_end),
        .wfifo_usedw(wfifo_usedw), .rfifo_usedw(rfifo_usedw),
        .flag_wr_end(flag_wr_end), .flag_rd_end(flag_rd_end),
        .wr_req(wr_req), .rd_req(rd_req),
        .wr_row(wr_row), .wr_col(wr_col), .rd_row(rd_row), .rd_col(rd_col),
        .sdram_bank_addr(sdram_bank_addr), .rd_bank(rd_bank),
        .wr_frame_done(wr_frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flag_init_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
        wfifo_usedw = 10'd0; rfifo_usedw = 10'd500;
        step(); step();
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic init_pulse();
        flag_init_end = 1'b1;
        step();
        flag_init_end = 1'b0;
    endtask

    task automatic pulse_wr();
        flag_wr_end = 1'b1;
        step();
        flag_wr_end = 1'b0;
    endtask

    task automatic pulse_rd();
        flag_rd_end = 1'b1;
        step();
        flag_rd_end = 1'b0;
    endtask

    task automatic wait_req(input bit is_wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((is_wr ? wr_req : rd_req) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        flag_init_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
        wfifo_usedw = 10'd300; rfifo_usedw = 10'd0;
        step(); step();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_req, rd_req, wr_frame_done} !== 3'b000) begin
            errors++; $display("FAIL reset_req: got %b want 000", {wr_req, rd_req, wr_frame_done});
        end
        checks++;
        if ({wr_row, wr_col, rd_row, rd_col} !== 44'd0) begin
            errors++; $display("FAIL reset_addr: wr %0d/%0d rd %0d/%0d want all 0", wr_row, wr_col, rd_row, rd_col);
        end
        checks++;
        if ({sdram_bank_addr, rd_bank} !== 4'd0) begin
            errors++; $display("FAIL reset_bank: got %b/%b want 00/00", sdram_bank_addr, rd_bank);
        end
        step();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({wr_req, rd_req} !== 2'b00) begin
            errors++; $display("FAIL init_no_req: got %b want 00", {wr_req, rd_req});
        end
    endtask

    task automatic test_first_write();
        do_reset();
        wfifo_usedw = 10'd256; rfifo_usedw = 10'd500;
        init_pulse();
        checks++;
        if (wr_req !== 1'b0) begin
            errors++; $display("FAIL first_wr_early: wr_req=%b want 0", wr_req);
        end
        step();
        checks++;
        if (wr_req !== 1'b1 || rd_req !== 1'b0) begin
            errors++; $display("FAIL first_wr_req: wr=%b rd=%b want 1 0", wr_req, rd_req);
        end
        checks++;
        if (wr_row !== 13'd0 || wr_col !== 9'd0) begin
            errors++; $display("FAIL first_wr_addr: row=%0d col=%0d want 0 0", wr_row, wr_col);
        end
    endtask

    task automatic test_priority_and_ignore();
        bit ok;
        do_reset();
        wfifo_usedw = 10'd300; rfifo_usedw = 10'd10;
        init_pulse();
        wait_req(1'b1, ok);
        checks++;
        if (!ok || rd_req !== 1'b0) begin
            errors++; $display("FAIL prio_wr_first: wr=%b rd=%b want 1 0", wr_req, rd_req);
        end
        wfifo_usedw = 10'd0;
        pulse_wr();
        checks++;
        if ({wr_req, rd_req} !== 2'b00 || wr_col !== 9'd256) begin
            errors++; $display("FAIL prio_gap: req=%b col=%0d want 00 256", {wr_req, rd_req}, wr_col);
        end
        step();
        checks++;
        if (rd_req !== 1'b1 || wr_req !== 1'b0 || rd_col !== 9'd0) begin
            errors++; $display("FAIL prio_rd_next: rd=%b wr=%b rd_col=%0d want 1 0 0", rd_req, wr_req, rd_col);
        end
        pulse_rd();
        rfifo_usedw = 10'd500; wfifo_usedw = 10'd300;
        step();
        checks++;
        if (wr_req !== 1'b1 || rd_col !== 9'd256) begin
            errors++; $display("FAIL second_wr: wr=%b rd_col=%0d want 1 256", wr_req, rd_col);
        end
        pulse_rd();
        checks++;
        if (wr_req !== 1'b1 || rd_req !== 1'b0 || rd_col !== 9'd256 || rd_row !== 13'd0 || wr_col !== 9'd256) begin
            errors++; $display("FAIL ignore_rd_in_wr: wr=%b rd=%b rd=%0d/%0d wr_col=%0d want 1 0 0/256 256",
                               wr_req, rd_req, rd_row, rd_col, wr_col);
        end
        wfifo_usedw = 10'd0;
        pulse_wr();
        checks++;
        if (wr_row !== 13'd1 || wr_col !== 9'd0) begin
            errors++; $display("FAIL wr_row_adv: row=%0d col=%0d want 1 0", wr_row, wr_col);
        end
        pulse_wr();
        checks++;
        if (wr_row !== 13'd1 || wr_col !== 9'd0 || wr_req !== 1'b0) begin
            errors++; $display("FAIL ignore_wr_in_idle: row=%0d col=%0d req=%b want 1 0 0", wr_row, wr_col, wr_req);
        end
    endtask

    task automatic test_write_frame();
        bit ok;
        int done_cnt = 0;
        do_reset();
        wfifo_usedw = 10'd300; rfifo_usedw = 10'd500;
        init_pulse();
        for (int b = 1; b <= 2400; b++) begin
            wait_req(1'b1, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL wr_frame_timeout: burst %0d got no wr_req", b);
                break;
            end
            if (b == 2400) wfifo_usedw = 10'd0;
            pulse_wr();
            if (wr_frame_done === 1'b1) done_cnt++;
            if (b == 2) begin
                checks++;
                if (wr_row !== 13'd1 || wr_col !== 9'd0) begin
                    errors++; $display("FAIL two_bursts: row=%0d col=%0d want 1 0", wr_row, wr_col);
                end
            end
            if (b == 2399) begin
                checks++;
                if (wr_row !== 13'd1199 || wr_col !== 9'd256 || done_cnt != 0) begin
                    errors++; $display("FAIL pre_wrap: row=%0d col=%0d done=%0d want 1199 256 0", wr_row, wr_col, done_cnt);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || wr_row !== 13'd0 || wr_col !== 9'd0) begin
            errors++; $display("FAIL frame_wrap: done=%0d row=%0d col=%0d want 1 0 0", done_cnt, wr_row, wr_col);
        end
        checks++;
        if (sdram_bank_addr !== EXP_WBANK_AFTER_FRAME) begin
            errors++; $display("FAIL wr_bank: got %0d want %0d", sdram_bank_addr, EXP_WBANK_AFTER_FRAME);
        end
        step();
        checks++;
        if (wr_frame_done !== 1'b0 || wr_req !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle: done=%b wr_req=%b want 0 0", wr_frame_done, wr_req);
        end
    endtask

    task automatic test_read_frame();
        bit ok;
        int done_cnt = 0;
        rfifo_usedw = 10'd10;
        for (int b = 1; b <= 2400; b++) begin
            wait_req(1'b0, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL rd_frame_timeout: burst %0d got no rd_req", b);
                break;
            end
            if (wr_req === 1'b1) done_cnt++;
            pulse_rd();
            if (wr_frame_done === 1'b1) done_cnt++;
            if (b == 3) begin
                checks++;
                if (rd_row !== 13'd1 || rd_col !== 9'd256) begin
                    errors++; $display("FAIL rd_adv: row=%0d col=%0d want 1 256", rd_row, rd_col);
                end
            end
        end
        checks++;
        if (rd_row !== 13'd0 || rd_col !== 9'd0 || done_cnt != 0 || wr_row !== 13'd0) begin
            errors++; $display("FAIL rd_wrap: row=%0d col=%0d stray=%0d wr_row=%0d want 0 0 0 0",
                               rd_row, rd_col, done_cnt, wr_row);
        end
        checks++;
        if (rd_bank !== 2'd0 || sdram_bank_addr !== EXP_WBANK_AFTER_FRAME) begin
            errors++; $display("FAIL pingpong_banks: rd_bank=%0d wr_bank=%0d want 0 %0d",
                               rd_bank, sdram_bank_addr, EXP_WBANK_AFTER_FRAME);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        do_reset();
        wfifo_usedw = 10'd300; rfifo_usedw = 10'd500;
        init_pulse();
        wait_req(1'b1, ok);
        pulse_wr();
        wait_req(1'b1, ok);
        checks++;
        if (!ok || wr_col !== 9'd256) begin
            errors++; $display("FAIL mid_setup: wr_req=%b col=%0d want 1 256", wr_req, wr_col);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_req !== 1'b0 || wr_col !== 9'd0) begin
            errors++; $display("FAIL async_reset: wr_req=%b col=%0d want 0 0", wr_req, wr_col);
        end
        step();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({wr_req, rd_req} !== 2'b00) begin
            errors++; $display("FAIL wait_init_again: req=%b want 00", {wr_req, rd_req});
        end
        init_pulse();
        step();
        checks++;
        if (wr_req !== 1'b1 || wr_col !== 9'd0) begin
            errors++; $display("FAIL resume_after_init: wr_req=%b col=%0d want 1 0", wr_req, wr_col);
        end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_priority_and_ignore();
        test_write_frame();
        test_read_frame();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_req === 1'b1 && rd_req === 1'b1) begin
            errors++;
            $display("FAIL mutual_excl: wr_req=1 rd_req=1 want never both");
        end
    end

endmodule
